// File: rtl/ifb_axi_rd_bridge_pkg.sv
// Shared encodings for the instruction-fetch burst to AXI read bridge.
// FSM states, AXI burst/resp codes and the 8-byte beat size code.
package ifb_axi_rd_bridge_pkg;

  typedef enum logic [1:0] {
    IFB_IDLE  = 2'd0,
    IFB_AR    = 2'd1,
    IFB_RDATA = 2'd2,
    IFB_DONE  = 2'd3
  } ifb_state_e;

  localparam logic [1:0] SIZE_D         = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Index of the final beat; len 2'b00 encodes 4 beats, so it wraps to 3.
  function automatic logic [1:0] last_beat(input logic [1:0] len);
    return len - 2'd1;
  endfunction

endpackage

// File: rtl/ifb_axi_rd_bridge_if.sv
// Icache burst request side plus AXI4 AR/R channels of the fetch bridge.
// slave = bridge view, master = icache/memory environment view.
interface ifb_axi_rd_bridge_if #(
  parameter int ADDR_W = 64
);

  logic              if_burst_valid;
  logic [ADDR_W-5:0] if_burst_addr;
  logic [1:0]        if_burst_len;
  logic [1:0]        if_burst_size;
  logic              if_burst_ready;
  logic [63:0]       if_burst_data;
  logic              if_burst_err;

  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [3:0]        ar_id;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;

  logic              r_valid;
  logic [63:0]       r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              r_ready;

  modport slave (
    input  if_burst_valid, if_burst_addr,
    input  if_burst_len, if_burst_size,
    output if_burst_ready, if_burst_data,
    output if_burst_err,
    output ar_valid, ar_addr, ar_id,
    output ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last,
    output r_ready
  );

  modport master (
    output if_burst_valid, if_burst_addr,
    output if_burst_len, if_burst_size,
    input  if_burst_ready, if_burst_data,
    input  if_burst_err,
    input  ar_valid, ar_addr, ar_id,
    input  ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last,
    input  r_ready
  );

endinterface

// File: rtl/ifb_axi_rd_bridge.sv
// Fetch burst responder: one icache line request -> one AXI4 INCR read.
// Optional macro IFB_RRESP_ERR_EN enables the sticky if_burst_err flag.
module ifb_axi_rd_bridge
  import ifb_axi_rd_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0,
  parameter int         ADDR_W = 64
) (
  input logic               cpu_clk_50M,
  input logic               cpu_rst,
  ifb_axi_rd_bridge_if.slave bus
);

  ifb_state_e        r_state;
  ifb_state_e        w_state_nxt;
  logic [ADDR_W-5:0] r_addr;
  logic [1:0]        r_len;
  logic [1:0]        r_size;
  logic [1:0]        r_cnt;
  logic              r_pulse;
  logic [63:0]       r_data;

  logic              w_start;
  logic              w_in_ar;
  logic              w_beat;
  logic [1:0]        w_last_idx;
  logic              w_is_last;

  assign w_start    = (r_state == IFB_IDLE)
                    & bus.if_burst_valid;
  assign w_in_ar    = (r_state == IFB_AR);
  assign w_beat     = (r_state == IFB_RDATA)
                    & bus.r_valid;
  assign w_last_idx = last_beat(r_len);
  assign w_is_last  = (r_cnt == w_last_idx);

  // State register; reset abandons any in-flight burst.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) r_state <= IFB_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: ends on beat count only, r_last never terminates.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IFB_IDLE:
        if (bus.if_burst_valid)
          w_state_nxt = IFB_AR;
      IFB_AR:
        if (bus.ar_ready)
          w_state_nxt = IFB_RDATA;
      IFB_RDATA:
        if (w_beat && w_is_last)
          w_state_nxt = IFB_DONE;
      IFB_DONE:
        w_state_nxt = IFB_IDLE;
      default:
        w_state_nxt = IFB_IDLE;
    endcase
  end

  // Capture the request when leaving IDLE; AR payload comes from here.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
    end else if (w_start) begin
      r_addr <= bus.if_burst_addr;
      r_len  <= bus.if_burst_len;
      r_size <= bus.if_burst_size;
    end
  end

  // Beat counter, cleared as the burst enters AR.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst)     r_cnt <= '0;
    else if (w_start) r_cnt <= '0;
    else if (w_beat)  r_cnt <= r_cnt + 2'd1;
  end

  // One-cycle delayed beat pulse; data is zero outside the pulse.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_pulse <= 1'b0;
      r_data  <= '0;
    end else begin
      r_pulse <= w_beat;
      r_data  <= w_beat ? bus.r_data : '0;
    end
  end

`ifdef IFB_RRESP_ERR_EN
  logic r_err;
  logic w_bad;

  assign w_bad = (bus.r_resp != AXI_RESP_OKAY)
               | (bus.r_last != w_is_last);

  // Sticky per-burst error, cleared as a new burst enters AR.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst)               r_err <= 1'b0;
    else if (w_start)          r_err <= 1'b0;
    else if (w_beat && w_bad)  r_err <= 1'b1;
  end

  assign bus.if_burst_err = r_err;
`else
  logic w_unused;

  assign w_unused = ^{bus.r_resp, bus.r_last};
  assign bus.if_burst_err = 1'b0;
`endif

  assign bus.ar_valid = w_in_ar;
  assign bus.ar_addr  = w_in_ar ? {r_addr, 4'b0000}
                                : '0;
  assign bus.ar_id    = w_in_ar ? AXI_ID : 4'h0;
  assign bus.ar_len   = w_in_ar ? {6'b0, w_last_idx}
                                : 8'h00;
  assign bus.ar_size  = w_in_ar ? {1'b0, r_size}
                                : 3'b000;
  assign bus.ar_burst = w_in_ar ? AXI_BURST_INCR
                                : 2'b00;
  assign bus.r_ready  = (r_state == IFB_RDATA);

  assign bus.if_burst_ready = r_pulse;
  assign bus.if_burst_data  = r_data;

endmodule

// File: tb/tb_ifb_axi_rd_bridge.sv
// Directed bench for the fetch burst to AXI read bridge.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ifb_axi_rd_bridge;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  int   pcnt;
  logic err_on;

  ifb_axi_rd_bridge_if bus ();

  ifb_axi_rd_bridge dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ar_valid"}, 64'(bus.ar_valid), 0);
    chk({tag, ".ar_addr"},  bus.ar_addr, 0);
    chk({tag, ".ar_id"},    64'(bus.ar_id), 0);
    chk({tag, ".ar_len"},   64'(bus.ar_len), 0);
    chk({tag, ".ar_size"},  64'(bus.ar_size), 0);
    chk({tag, ".ar_burst"}, 64'(bus.ar_burst), 0);
    chk({tag, ".r_ready"},  64'(bus.r_ready), 0);
    chk({tag, ".ready"},    64'(bus.if_burst_ready), 0);
    chk({tag, ".data"},     bus.if_burst_data, 0);
    chk({tag, ".err"},      64'(bus.if_burst_err), 0);
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.if_burst_ready) pcnt++;
  endtask

  task automatic beat(input logic [63:0] d,
                      input logic [1:0] resp,
                      input logic last);
    bus.r_valid = 1'b1;
    bus.r_data  = d;
    bus.r_resp  = resp;
    bus.r_last  = last;
  endtask

  task automatic no_beat();
    bus.r_valid = 1'b0;
    bus.r_data  = '0;
    bus.r_resp  = 2'b00;
    bus.r_last  = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    pcnt = 0;
`ifdef IFB_RRESP_ERR_EN
    err_on = 1'b1;
`else
    err_on = 1'b0;
`endif
    rst = 1'b1;
    bus.if_burst_valid = 1'b0;
    bus.if_burst_addr  = '0;
    bus.if_burst_len   = 2'b00;
    bus.if_burst_size  = 2'b00;
    bus.ar_ready       = 1'b0;
    no_beat();

    // 1: reset state
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // 2: basic two-beat burst
    bus.if_burst_valid = 1'b1;
    bus.if_burst_addr  = 60'h0800_0001;
    bus.if_burst_len   = 2'b10;
    bus.if_burst_size  = 2'b11;
    bus.ar_ready       = 1'b1;
    step();
    chk("b.ar_valid", 64'(bus.ar_valid), 1);
    chk("b.ar_addr",  bus.ar_addr, 64'h8000_0010);
    chk("b.ar_len",   64'(bus.ar_len), 1);
    chk("b.ar_size",  64'(bus.ar_size), 3);
    chk("b.ar_burst", 64'(bus.ar_burst), 1);
    chk("b.ar_id",    64'(bus.ar_id), 0);
    chk("b.r_ready0", 64'(bus.r_ready), 0);
    step();
    chk("b.ar_drop",  64'(bus.ar_valid), 0);
    chk("b.r_ready1", 64'(bus.r_ready), 1);
    chk("b.nopulse",  64'(bus.if_burst_ready), 0);
    beat(64'hA, 2'b00, 1'b0);
    step();
    chk("b.rdyA",     64'(bus.if_burst_ready), 1);
    chk("b.dataA",    bus.if_burst_data, 64'hA);
    chk("b.r_ready2", 64'(bus.r_ready), 1);
    beat(64'hB, 2'b00, 1'b1);
    step();
    chk("b.rdyB",     64'(bus.if_burst_ready), 1);
    chk("b.dataB",    bus.if_burst_data, 64'hB);
    chk("b.done_rr",  64'(bus.r_ready), 0);
    chk("b.err",      64'(bus.if_burst_err), 0);
    no_beat();
    bus.if_burst_valid = 1'b0;
    step();
    chk_zero("b.idle");

    // 1b: reset asserted mid-clock while in AR
    bus.if_burst_valid = 1'b1;
    step();
    chk("ra.ar_valid", 64'(bus.ar_valid), 1);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    bus.if_burst_valid = 1'b0;
    bus.ar_ready = 1'b0;
    step();
    chk_zero("ra.idle");

    // 3: AR stall, 4-beat burst, valid dropped mid-burst
    bus.if_burst_valid = 1'b1;
    bus.if_burst_addr  = 60'h1234_5678_9AB_CDEF;
    bus.if_burst_len   = 2'b00;
    bus.if_burst_size  = 2'b11;
    step();
    bus.if_burst_addr  = '0;
    bus.if_burst_len   = 2'b01;
    for (int i = 0; i < 5; i++) begin
      chk("s.ar_valid", 64'(bus.ar_valid), 1);
      chk("s.ar_addr",  bus.ar_addr,
          64'h1234_5678_9ABC_DEF0);
      chk("s.ar_len",   64'(bus.ar_len), 3);
      chk("s.r_ready",  64'(bus.r_ready), 0);
      if (i == 4) bus.ar_ready = 1'b1;
      step();
    end
    chk("s.ar_drop", 64'(bus.ar_valid), 0);
    chk("s.r_ready1", 64'(bus.r_ready), 1);
    bus.ar_ready = 1'b0;
    bus.if_burst_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(64'(100 + k), 2'b00, k == 3);
      step();
      chk("s.rdy",  64'(bus.if_burst_ready), 1);
      chk("s.data", bus.if_burst_data, 64'(100 + k));
      chk("s.rr",   64'(bus.r_ready), 64'(k != 3));
    end
    chk("s.err", 64'(bus.if_burst_err), 0);
    no_beat();
    step();
    chk_zero("s.idle");

    // 4: R gaps, then DONE for one cycle with valid held
    bus.if_burst_valid = 1'b1;
    bus.if_burst_addr  = 60'h0000_0000_0000_0040;
    bus.if_burst_len   = 2'b10;
    bus.ar_ready       = 1'b1;
    step();
    chk("g.ar_addr", bus.ar_addr, 64'h400);
    step();
    pcnt = 0;
    beat(64'hC, 2'b00, 1'b0);
    step();
    chk("g.dataC", bus.if_burst_data, 64'hC);
    no_beat();
    repeat (3) step();
    chk("g.rr_gap", 64'(bus.r_ready), 1);
    beat(64'hD, 2'b00, 1'b1);
    step();
    chk("g.dataD", bus.if_burst_data, 64'hD);
    chk("g.done",  64'(bus.r_ready), 0);
    no_beat();
    bus.if_burst_addr = 60'h0000_0000_0000_0100;
    step();
    chk("g.pulses", 64'(pcnt), 2);
    chk("g.idle_ar", 64'(bus.ar_valid), 0);
    chk("g.idle_rr", 64'(bus.r_ready), 0);
    chk("g.err0",   64'(bus.if_burst_err), 0);

    // 5: error response on beat 0 of the re-issued burst
    step();
    chk("e.ar_valid", 64'(bus.ar_valid), 1);
    chk("e.ar_addr",  bus.ar_addr, 64'h1000);
    step();
    beat(64'hE, 2'b10, 1'b0);
    step();
    chk("e.dataE", bus.if_burst_data, 64'hE);
    chk("e.err_b0", 64'(bus.if_burst_err), 64'(err_on));
    beat(64'hF, 2'b00, 1'b1);
    step();
    chk("e.dataF", bus.if_burst_data, 64'hF);
    chk("e.err_done", 64'(bus.if_burst_err), 64'(err_on));
    no_beat();
    step();
    chk("e.err_idle", 64'(bus.if_burst_err), 64'(err_on));
    step();
    chk("e.ar2", 64'(bus.ar_valid), 1);
    chk("e.err_clr", 64'(bus.if_burst_err), 0);

    // 6: reset after beat 0 of a 2-beat burst
    step();
    beat(64'h66, 2'b00, 1'b0);
    step();
    chk("r.data0", bus.if_burst_data, 64'h66);
    no_beat();
    bus.if_burst_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero("r.rst");
    @(negedge clk);
    rst = 1'b0;
    bus.if_burst_valid = 1'b1;
    bus.if_burst_addr  = 60'h0000_0000_0000_0777;
    bus.if_burst_len   = 2'b10;
    step();
    chk("r.ar_valid", 64'(bus.ar_valid), 1);
    chk("r.ar_addr",  bus.ar_addr, 64'h7770);
    step();
    bus.if_burst_valid = 1'b0;
    beat(64'h77, 2'b00, 1'b0);
    step();
    chk("r.data1", bus.if_burst_data, 64'h77);
    chk("r.rr_mid", 64'(bus.r_ready), 1);
    beat(64'h88, 2'b00, 1'b1);
    step();
    chk("r.data2", bus.if_burst_data, 64'h88);
    chk("r.done",  64'(bus.r_ready), 0);
    chk("r.err",   64'(bus.if_burst_err), 0);
    no_beat();
    step();
    chk_zero("r.idle");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
